// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Finite-state control for the multicycle ARM-subset datapath. Each
// instruction is sequenced through FETCH / DECODE / address-or-execute /
// memory / writeback so that one memory port and one ALU can be shared.
// Also holds the NZCV flag register and the condition result latched in
// DECODE, and optionally stretches memory states until MemReady.
//
// Parameters
//   MEM_HANDSHAKE : 1 = FETCH/MEMREAD/MEMWRITE hold until MemReady,
//                   0 = memory is single-cycle, MemReady ignored.
//   COND_EN       : 1 = ARM condition field evaluated, 0 = always execute.
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   Cond, Op, Funct, Rd   instruction fields from IR
//   ALUFlags              {N,Z,C,V} from the ALU this cycle
//   MemReady              memory finished its access this cycle
//   PCWrite, IRWrite,
//   RegWrite, MemWrite,
//   MemReq                datapath strobes (all low while in reset)
//   AdrSrc, ResultSrc,
//   ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc,
//   RegSrc                datapath mux selects / ALU operation
//   Flags                 registered NZCV
//   State                 current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter bit MEM_HANDSHAKE = 1'b0,
  parameter bit COND_EN       = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_t;

  state_t     state;
  logic [3:0] flags;
  logic       cond_ex_r;

  logic       ready;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_raw;
  logic       cond_ex;
  alu_t       alu_dec;
  logic       cmd_known;

  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       alu_op;
  logic       reg_w;
  logic       mem_w;
  logic       mem_req;
  logic       branch;
  logic       fetch;
  logic       pcs;

  // Without the handshake every memory access completes in its own cycle.
  assign ready = MEM_HANDSHAKE ? MemReady : 1'b1;

  // ---------------------------------------------------------------------
  // Condition evaluation against the registered flags.
  // ---------------------------------------------------------------------
  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    cond_raw = 1'b0;
    case (Cond)
      4'b0000: cond_raw = flag_z;                          // EQ
      4'b0001: cond_raw = ~flag_z;                         // NE
      4'b0010: cond_raw = flag_c;                          // CS
      4'b0011: cond_raw = ~flag_c;                         // CC
      4'b0100: cond_raw = flag_n;                          // MI
      4'b0101: cond_raw = ~flag_n;                         // PL
      4'b0110: cond_raw = flag_v;                          // VS
      4'b0111: cond_raw = ~flag_v;                         // VC
      4'b1000: cond_raw = flag_c & ~flag_z;                // HI
      4'b1001: cond_raw = ~flag_c | flag_z;                // LS
      4'b1010: cond_raw = (flag_n == flag_v);              // GE
      4'b1011: cond_raw = (flag_n != flag_v);              // LT
      4'b1100: cond_raw = ~flag_z & (flag_n == flag_v);    // GT
      4'b1101: cond_raw = flag_z | (flag_n != flag_v);     // LE
      4'b1110: cond_raw = 1'b1;                            // AL
      default: cond_raw = 1'b0;                            // 1111: never
    endcase
  end

  assign cond_ex = COND_EN ? cond_raw : 1'b1;

  // ---------------------------------------------------------------------
  // Data-processing command decode. Unknown commands run as ADD but are
  // not allowed to write back.
  // ---------------------------------------------------------------------
  always_comb begin
    alu_dec   = ALU_ADD;
    cmd_known = 1'b1;
    case (Funct[4:1])
      4'b0100: alu_dec = ALU_ADD;
      4'b0010: alu_dec = ALU_SUB;
      4'b0000: alu_dec = ALU_AND;
      4'b1100: alu_dec = ALU_ORR;
      default: cmd_known = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // State, flags and latched condition.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_FETCH;
      flags     <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        S_FETCH: if (ready) state <= S_DECODE;
        S_DECODE: begin
          cond_ex_r <= cond_ex;
          case (Op)
            2'b00:   state <= Funct[5] ? S_EXECUTEI : S_EXECUTER;
            2'b01:   state <= S_MEMADR;
            2'b10:   state <= S_BRANCH;
            default: state <= S_FETCH;   // undefined opcode
          endcase
        end
        S_MEMADR:   state <= Funct[0] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (ready) state <= S_MEMWB;
        S_MEMWRITE: if (ready) state <= S_FETCH;
        S_EXECUTER, S_EXECUTEI: begin
          state <= S_ALUWB;
          if (Funct[0] && cond_ex_r) begin
            flags[3:2] <= ALUFlags[3:2];
            // Logical ops leave carry and overflow alone.
            if (alu_dec == ALU_ADD || alu_dec == ALU_SUB)
              flags[1:0] <= ALUFlags[1:0];
          end
        end
        default: state <= S_FETCH;     // MEMWB, ALUWB, BRANCH, unused codes
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Moore output decode.
  // ---------------------------------------------------------------------
  always_comb begin
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    mem_req    = 1'b0;
    branch     = 1'b0;
    fetch      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        fetch      = 1'b1;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMREAD: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECUTER: alu_op = 1'b1;
      S_EXECUTEI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      S_ALUWB: reg_w = cmd_known;
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcs = branch | (reg_w & (Rd == 4'd15));

  assign AdrSrc     = adr_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ResultSrc  = result_src;
  assign ALUControl = alu_op ? alu_dec : ALU_ADD;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign Flags      = flags;
  assign State      = state;

  // Strobes are masked by RST_N directly: the reset state is FETCH, whose
  // request/load strobes must not reach the datapath until reset releases.
  assign MemReq   = RST_N & mem_req;
  assign IRWrite  = RST_N & fetch & ready;
  assign PCWrite  = RST_N & ((fetch & ready) | (pcs & cond_ex_r));
  assign RegWrite = RST_N & reg_w & cond_ex_r;
  assign MemWrite = RST_N & mem_w & cond_ex_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Drives instruction fields, ALU flags and MemReady into the control unit
// (handshake enabled) and compares every cycle against a transaction-level
// model: each instruction is expanded into its expected list of cycles
// (phase, strobes, selects) from its class, its condition outcome and the
// chosen memory wait counts; the NZCV register is tracked separately.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic       CLK;
  logic       RST_N;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemReq, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic       ALUSrcA;
  logic [3:0] Flags, State;

  multicycle_control_unit #(.MEM_HANDSHAKE(1'b1), .COND_EN(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemReq(MemReq), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .Flags(Flags), .State(State)
  );

  // One expected cycle: phase number, {PCWrite,IRWrite,RegWrite,MemWrite,
  // MemReq}, {AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUControl}, and the
  // MemReady / ALUFlags values the bench applies in that cycle.
  typedef struct packed {
    logic [3:0] st;
    logic [4:0] strb;
    logic [7:0] mux;
    logic       rdy;
    logic [3:0] af;
  } cyc_t;

  cyc_t       q[$];
  logic [5:0] sel_tbl [10];   // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB} per phase
  logic [3:0] m_flags;
  logic [1:0] cur_op;
  logic [5:0] cur_funct;
  logic [3:0] cur_rd;
  logic       cur_pass;
  int         n_vec;
  int         n_miss;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ARM conditions come in complementary pairs: Cond[3:1] picks the test,
  // Cond[0] inverts it (AL/never included).
  function automatic logic holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return cond[0] ? ~base : base;
  endfunction

  function automatic logic known(input logic [3:0] cmd);
    return cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100;
  endfunction

  function automatic logic [1:0] alu_code(input logic [3:0] cmd);
    case (cmd)
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Append one expected cycle for phase st of the current instruction.
  task automatic push(input int st, input logic rdy, input logic [3:0] af);
    cyc_t c;
    logic wb;
    wb       = (st == 4) || (st == 8 && known(cur_funct[4:1]));
    c.st     = 4'(st);
    c.rdy    = rdy;
    c.af     = af;
    c.strb[4] = (st == 0 && rdy) || (st == 9 && cur_pass) ||
                (wb && cur_pass && cur_rd == 4'd15);
    c.strb[3] = (st == 0 && rdy);
    c.strb[2] = wb && cur_pass;
    c.strb[1] = (st == 5) && cur_pass;
    c.strb[0] = (st == 0 || st == 3 || st == 5);
    c.mux    = {sel_tbl[st], (st == 6 || st == 7) ? alu_code(cur_funct[4:1]) : 2'b00};
    q.push_back(c);
  endtask

  // Run one instruction. fw/mw are wait cycles in FETCH and in the memory
  // phase; ex_af is the ALU flag value during execute. abort_at >= 0
  // asserts reset during that cycle and ends the instruction there.
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd,
                           input int fw, input int mw,
                           input logic [3:0] ex_af, input int abort_at);
    cur_op    = op;
    cur_funct = funct;
    cur_rd    = rd;
    cur_pass  = holds(cond, m_flags);
    Cond = cond; Op = op; Funct = funct; Rd = rd;
    q.delete();
    repeat (fw) push(0, 1'b0, rnd4());
    push(0, 1'b1, rnd4());
    push(1, rnd1(), rnd4());
    case (op)
      2'b01: begin
        push(2, rnd1(), rnd4());
        if (funct[0]) begin
          repeat (mw) push(3, 1'b0, rnd4());
          push(3, 1'b1, rnd4());
          push(4, rnd1(), rnd4());
        end else begin
          repeat (mw) push(5, 1'b0, rnd4());
          push(5, 1'b1, rnd4());
        end
      end
      2'b00: begin
        push(funct[5] ? 7 : 6, rnd1(), ex_af);
        push(8, rnd1(), rnd4());
      end
      2'b10:   push(9, rnd1(), rnd4());
      default: ;
    endcase

    for (int i = 0; i < q.size(); i++) begin
      MemReady = q[i].rdy;
      ALUFlags = q[i].af;
      @(negedge CLK);
      check("state", State, q[i].st);
      check("strobes", {PCWrite, IRWrite, RegWrite, MemWrite, MemReq}, q[i].strb);
      check("selects", {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}, q[i].mux);
      check("imm_reg_src", {ImmSrc, RegSrc}, {op, op == 2'b01, op == 2'b10});
      if (i == abort_at) begin
        #2 RST_N = 1'b0;
        #1;
        check("abort_strobes", {PCWrite, IRWrite, RegWrite, MemWrite, MemReq}, 5'b0);
        check("abort_state", State, 4'd0);
        check("abort_flags", Flags, 4'd0);
        m_flags = 4'b0000;
        @(posedge CLK);
        #2 RST_N = 1'b1;
        return;
      end
      @(posedge CLK);
      #1;
    end

    if (op == 2'b00 && funct[0] && cur_pass) begin
      m_flags[3:2] = ex_af[3:2];
      if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010)
        m_flags[1:0] = ex_af[1:0];
    end
    check("flags", Flags, m_flags);
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    m_flags  = 4'b0000;
    sel_tbl  = '{6'b0_10_1_10, 6'b0_10_1_10, 6'b0_00_0_01, 6'b1_00_0_00,
                 6'b0_01_0_00, 6'b1_00_0_00, 6'b0_00_0_00, 6'b0_00_0_01,
                 6'b0_00_0_00, 6'b0_10_0_01};
    RST_N    = 1'b0;
    Cond     = 4'hE;
    Op       = 2'b00;
    Funct    = 6'b0;
    Rd       = 4'd0;
    ALUFlags = 4'hF;
    MemReady = 1'b1;

    // Reset: FETCH, cleared flags, no strobes even with MemReady high.
    repeat (3) begin
      @(negedge CLK);
      check("reset_state", State, 4'd0);
      check("reset_flags", Flags, 4'd0);
      check("reset_strobes", {PCWrite, IRWrite, RegWrite, MemWrite, MemReq}, 5'b0);
    end
    @(posedge CLK);
    #2 RST_N = 1'b1;

    // ADDS R1,R2,R3 with ALUFlags 0110 in execute.
    run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 0, 0, 4'b0110, -1);
    // Clear Z with ADDS, then SUBEQ must be skipped.
    run_instr(4'hE, 2'b00, 6'b001001, 4'd2, 0, 0, 4'b0000, -1);
    run_instr(4'h0, 2'b00, 6'b000101, 4'd3, 0, 0, 4'b1111, -1);
    // LDR with two wait cycles in MEMREAD.
    run_instr(4'hE, 2'b01, 6'b011001, 4'd4, 0, 2, 4'b0000, -1);
    // Branch never / always.
    run_instr(4'hF, 2'b10, 6'b100000, 4'd0, 0, 0, 4'b0000, -1);
    run_instr(4'hE, 2'b10, 6'b100000, 4'd0, 0, 0, 4'b0000, -1);
    // Undefined opcode, ALU write to PC, ANDS keeping C/V.
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 1, 0, 4'b0000, -1);
    run_instr(4'hE, 2'b00, 6'b111000, 4'd15, 0, 0, 4'b0000, -1);
    run_instr(4'hE, 2'b00, 6'b001001, 4'd5, 0, 0, 4'b1011, -1);
    run_instr(4'hE, 2'b00, 6'b100001, 4'd5, 0, 0, 4'b0100, -1);
    // Reset during a waiting STR: first MEMWRITE cycle is index 3.
    run_instr(4'hE, 2'b01, 6'b011000, 4'd6, 0, 2, 4'b0000, 3);

    for (int k = 0; k < 400; k++) begin
      logic [3:0] c, r;
      logic [1:0] o;
      logic [5:0] f;
      int         fw, mw;
      o  = 2'($urandom_range(0, 3));
      f  = 6'($urandom_range(0, 63));
      if (o == 2'b00 && !known(f[4:1])) f[0] = 1'b0;
      c  = rnd1() ? 4'hE : rnd4();
      r  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(c, o, f, r, fw, mw, rnd4(), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
